// File: rtl/qpsk_phase_mux_if.sv
// Parallel DDS I/Q sample bus into the QPSK phase mux and its phase-shifted result.
// The master drives samples and phase; the slave returns the registered output.
interface qpsk_phase_mux_if #(
    parameter int unsigned N_bits = 16,
    parameter int unsigned N_para = 8
);
    logic [N_para*N_bits-1:0] dds_i;
    logic [N_para*N_bits-1:0] dds_q;
    logic                     in_valid;
    logic [1:0]               RF_phase;
    logic [N_para*N_bits-1:0] signal_out;
    logic                     out_valid;

    modport master (
        output dds_i,
        output dds_q,
        output in_valid,
        output RF_phase,
        input  signal_out,
        input  out_valid
    );

    modport slave (
        input  dds_i,
        input  dds_q,
        input  in_valid,
        input  RF_phase,
        output signal_out,
        output out_valid
    );
endinterface

// File: rtl/qpsk_phase_mux.sv
// Per-lane quadrature phase selector (I, Q, -I, -Q) with a one-cycle registered output.
// Define QPSK_NEG_SATURATE_EN to saturate negation of the most-negative sample.
module qpsk_phase_mux #(
    parameter int unsigned N_bits = 16,
    parameter int unsigned N_para = 8
) (
    input logic              clk,
    input logic              rst_n,
    qpsk_phase_mux_if.slave  bus
);

    localparam int unsigned W = N_bits * N_para;

    localparam logic [N_bits-1:0] MinVal = {1'b1, {(N_bits-1){1'b0}}};
    localparam logic [N_bits-1:0] MaxVal = {1'b0, {(N_bits-1){1'b1}}};
    localparam logic [N_bits-1:0] OneVal = {{(N_bits-1){1'b0}}, 1'b1};

    function automatic logic [N_bits-1:0] f_neg(input logic [N_bits-1:0] x);
        logic [N_bits-1:0] y;
        y = ~x + OneVal;
`ifdef QPSK_NEG_SATURATE_EN
        // -MinVal is not representable; clamp to the largest positive value.
        if (x == MinVal) y = MaxVal;
`else
        if (x == MinVal) y = MinVal;
`endif
        return y;
    endfunction

    logic [W-1:0] w_sel;
    logic [W-1:0] r_out;
    logic         r_valid;

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < int'(N_para); k++) begin
            unique case (bus.RF_phase)
                2'b00: w_sel[k*N_bits +: N_bits] = bus.dds_i[k*N_bits +: N_bits];
                2'b01: w_sel[k*N_bits +: N_bits] = bus.dds_q[k*N_bits +: N_bits];
                2'b11: w_sel[k*N_bits +: N_bits] = f_neg(bus.dds_i[k*N_bits +: N_bits]);
                2'b10: w_sel[k*N_bits +: N_bits] = f_neg(bus.dds_q[k*N_bits +: N_bits]);
            endcase
        end
    end

    // Data holds across idle beats; only the valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) r_out <= w_sel;
        end
    end

    assign bus.signal_out = r_out;
    assign bus.out_valid  = r_valid;

endmodule

// File: tb/tb_qpsk_phase_mux.sv
// Scoreboard bench for qpsk_phase_mux: an 8-lane and a 4-lane instance share stimulus.
// Expected lanes come from an integer-arithmetic model of the phase rotation.
module tb_qpsk_phase_mux;

    localparam int unsigned NB = 16;
    localparam int unsigned W8 = NB * 8;
    localparam int unsigned W4 = NB * 4;

`ifdef QPSK_NEG_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [W8-1:0] data;
        logic          valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;
    exp_t sb_q[$];
    logic [W8-1:0] last_exp = '0;

    qpsk_phase_mux_if #(.N_bits(NB), .N_para(8)) bus8 ();
    qpsk_phase_mux_if #(.N_bits(NB), .N_para(4)) bus4 ();

    qpsk_phase_mux #(.N_bits(NB), .N_para(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    qpsk_phase_mux #(.N_bits(NB), .N_para(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NB-1:0] model_lane(input logic [NB-1:0] i, input logic [NB-1:0] q,
                                                 input logic [1:0] ph);
        int v;
        case (ph)
            2'b00:   v = int'($signed(i));
            2'b01:   v = int'($signed(q));
            2'b11:   v = -int'($signed(i));
            default: v = -int'($signed(q));
        endcase
        if (v > 32767) v = SAT ? 32767 : v - 65536;
        return v[NB-1:0];
    endfunction

    function automatic logic [W8-1:0] model(input logic [W8-1:0] di, input logic [W8-1:0] dq,
                                            input logic [1:0] ph);
        logic [W8-1:0] r;
        for (int k = 0; k < 8; k++)
            r[k*NB +: NB] = model_lane(di[k*NB +: NB], dq[k*NB +: NB], ph);
        return r;
    endfunction

    task automatic check(input string tag, input logic [W8-1:0] obs, input logic [W8-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W8-1:0] di, input logic [W8-1:0] dq, input logic [1:0] ph,
                         input logic v);
        bus8.dds_i = di;
        bus8.dds_q = dq;
        bus8.RF_phase = ph;
        bus8.in_valid = v;
        bus4.dds_i = di[W4-1:0];
        bus4.dds_q = dq[W4-1:0];
        bus4.RF_phase = ph;
        bus4.in_valid = v;
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        check("data8", bus8.signal_out, e.data);
        check("valid8", {{(W8-1){1'b0}}, bus8.out_valid}, {{(W8-1){1'b0}}, e.valid});
        check("data4", {{(W8-W4){1'b0}}, bus4.signal_out}, {{(W8-W4){1'b0}}, e.data[W4-1:0]});
        check("valid4", {{(W8-1){1'b0}}, bus4.out_valid}, {{(W8-1){1'b0}}, e.valid});
    endtask

    task automatic beat(input logic [W8-1:0] di, input logic [W8-1:0] dq, input logic [1:0] ph,
                        input logic v);
        exp_t e;
        @(negedge clk);
        drive(di, dq, ph, v);
        if (v) last_exp = model(di, dq, ph);
        e.data = last_exp;
        e.valid = v;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    function automatic logic [W8-1:0] rand_word();
        logic [W8-1:0] r;
        for (int k = 0; k < 8; k++) r[k*NB +: NB] = NB'($urandom);
        return r;
    endfunction

    initial begin
        logic [W8-1:0] di;
        logic [W8-1:0] dq;
        drive('0, '0, 2'b00, 1'b0);

        // Reset state
        #12;
        check("reset_data", bus8.signal_out, '0);
        check("reset_valid", {{(W8-1){1'b0}}, bus8.out_valid}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lane 0 directed vector, all four phases
        di = rand_word();
        dq = rand_word();
        di[15:0] = 16'h1234;
        dq[15:0] = 16'h0FFF;
        beat(di, dq, 2'b00, 1'b1);
        check("p00_lane0", {{(W8-NB){1'b0}}, bus8.signal_out[15:0]}, {{(W8-NB){1'b0}}, 16'h1234});
        beat(di, dq, 2'b01, 1'b1);
        check("p01_lane0", {{(W8-NB){1'b0}}, bus8.signal_out[15:0]}, {{(W8-NB){1'b0}}, 16'h0FFF});
        beat(di, dq, 2'b11, 1'b1);
        check("p11_lane0", {{(W8-NB){1'b0}}, bus8.signal_out[15:0]}, {{(W8-NB){1'b0}}, 16'hEDCC});
        beat(di, dq, 2'b10, 1'b1);
        check("p10_lane0", {{(W8-NB){1'b0}}, bus8.signal_out[15:0]}, {{(W8-NB){1'b0}}, 16'hF001});

        // Per-lane independence under 180 deg
        di = rand_word();
        di[W4-1:0] = {16'h0000, 16'hFFFF, 16'h7FFF, 16'h0001};
        beat(di, rand_word(), 2'b11, 1'b1);
        check("lanes_neg", {{(W8-W4){1'b0}}, bus4.signal_out},
              {{(W8-W4){1'b0}}, 16'h0000, 16'h0001, 16'h8001, 16'hFFFF});

        // Idle beats hold data, drop valid
        beat(rand_word(), rand_word(), 2'b01, 1'b0);
        beat(rand_word(), rand_word(), 2'b00, 1'b0);

        // Most-negative sample through both negating phases
        di = rand_word();
        dq = rand_word();
        di[15:0] = 16'h8000;
        dq[31:16] = 16'h8000;
        beat(di, dq, 2'b11, 1'b1);
        check("edge_neg_i", {{(W8-NB){1'b0}}, bus8.signal_out[15:0]},
              {{(W8-NB){1'b0}}, SAT ? 16'h7FFF : 16'h8000});
        beat(di, dq, 2'b10, 1'b1);
        check("edge_neg_q", {{(W8-NB){1'b0}}, bus8.signal_out[31:16]},
              {{(W8-NB){1'b0}}, SAT ? 16'h7FFF : 16'h8000});

        // Random stream with phase changing every beat
        for (int n = 0; n < 24; n++)
            beat(rand_word(), rand_word(), 2'($urandom), ($urandom_range(0, 3) != 0));

        // Asynchronous reset mid-stream, with a beat in flight
        beat(rand_word(), rand_word(), 2'b01, 1'b1);
        @(negedge clk);
        drive(rand_word(), rand_word(), 2'b00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", bus8.signal_out, '0);
        check("async_rst_valid", {{(W8-1){1'b0}}, bus8.out_valid}, '0);
        check("async_rst_data4", {{(W8-W4){1'b0}}, bus4.signal_out}, '0);
        @(posedge clk);
        #1;
        check("rst_hold_valid", {{(W8-1){1'b0}}, bus8.out_valid}, '0);
        @(negedge clk);
        drive('0, '0, 2'b00, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_data", bus8.signal_out, '0);
        check("post_rst_valid", {{(W8-1){1'b0}}, bus8.out_valid}, '0);
        last_exp = '0;

        // First beats after reset
        for (int n = 0; n < 6; n++)
            beat(rand_word(), rand_word(), 2'($urandom), 1'b1);
        beat(rand_word(), rand_word(), 2'b11, 1'b0);

        check("scoreboard_drained", 128'(sb_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
